// File: rtl/arbhot.sv
// arbhot: round-robin arbiter with a registered one-hot grant that drives
// the select input of a one-hot data mux. It also provides a registered
// valid flag and the binary index of the current owner.
//
// Optional feature: define ARBHOT_HOLD_EN to lock a grant for as long as
// its owner keeps requesting (multi-cycle bursts). Without it the arbiter
// re-arbitrates on every enabled edge.
module arbhot #(
    parameter int N = 16,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic          gvalid,
    output logic [IW-1:0] gid
);

    // Last winner; the search starts one position after it.
    logic [IW-1:0] ptr;

    // Search results
    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [IW:0]   cand;

    // Hold decision
    logic          hold;

    // Next-state values
    logic [N-1:0]  grant_d;
    logic          gvalid_d;
    logic [IW-1:0] gid_d;
    logic [IW-1:0] ptr_d;

    // Rotating priority search: visit ptr+1, ptr+2, ... wrapping modulo N
    // explicitly so non-power-of-two N never produces an index >= N. The
    // previous winner (offset N) is examined last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!win_found && req[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

`ifdef ARBHOT_HOLD_EN
    // The current owner keeps the mux while it still requests.
    assign hold = gvalid && req[gid];
`else
    // Per-cycle round robin: never hold.
    assign hold = 1'b0;
`endif

    // Next-state selection: disable drops the grant, hold keeps it, otherwise
    // the search winner (if any) takes the mux.
    always_comb begin
        grant_d  = '0;
        gvalid_d = 1'b0;
        gid_d    = '0;
        ptr_d    = ptr;
        if (en) begin
            if (hold) begin
                grant_d  = grant;
                gvalid_d = gvalid;
                gid_d    = gid;
            end else if (win_found) begin
                grant_d[win_idx] = 1'b1;
                gvalid_d         = 1'b1;
                gid_d            = win_idx;
                ptr_d            = win_idx;
            end
        end
    end

    // State registers; reset makes requester 0 the first in line.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            grant  <= '0;
            gvalid <= 1'b0;
            gid    <= '0;
            ptr    <= IW'(N - 1);
        end else begin
            grant  <= grant_d;
            gvalid <= gvalid_d;
            gid    <= gid_d;
            ptr    <= ptr_d;
        end
    end

    // Structural invariants of the registered outputs.
    a_onehot: assert property (@(posedge clk) disable iff (!nreset)
        $onehot0(grant));
    a_valid: assert property (@(posedge clk) disable iff (!nreset)
        gvalid == (|grant));
    a_gid_range: assert property (@(posedge clk) disable iff (!nreset)
        gid <= IW'(N - 1));
    a_ptr_range: assert property (@(posedge clk) disable iff (!nreset)
        ptr <= IW'(N - 1));
    a_gid_zero: assert property (@(posedge clk) disable iff (!nreset)
        !gvalid |-> (gid == '0));

endmodule

// File: tb/tb_arbhot.sv
// tb_arbhot: directed checks of arbhot on a 4-requester instance plus a
// random invariant/fairness run on a 5-requester instance. Expectations
// follow ARBHOT_HOLD_EN when it is defined for the build.
module tb_arbhot;

`ifdef ARBHOT_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk = 1'b0;
    int         checks = 0;
    int         errors = 0;

    // 4-requester instance
    logic       nreset4;
    logic       en4;
    logic [3:0] req4;
    logic [3:0] grant4;
    logic       gvalid4;
    logic [1:0] gid4;

    // 5-requester instance
    logic       nreset5;
    logic       en5;
    logic [4:0] req5;
    logic [4:0] grant5;
    logic       gvalid5;
    logic [2:0] gid5;

    arbhot #(.N(4)) dut4 (
        .clk    (clk),
        .nreset (nreset4),
        .en     (en4),
        .req    (req4),
        .grant  (grant4),
        .gvalid (gvalid4),
        .gid    (gid4)
    );

    arbhot #(.N(5)) dut5 (
        .clk    (clk),
        .nreset (nreset5),
        .en     (en5),
        .req    (req5),
        .grant  (grant5),
        .gvalid (gvalid5),
        .gid    (gid5)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset4 = 1'b0;
        en4     = 1'b1;
        req4    = 4'b0000;
        tick();
        tick();
        if (grant4 !== 4'b0000 || gvalid4 !== 1'b0 || gid4 !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_state got grant=%b gvalid=%b gid=%0d exp 0000/0/0",
                     grant4, gvalid4, gid4);
        end
        checks++;
        #2 nreset4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (grant4 !== 4'b0000 || gvalid4 !== 1'b0 || gid4 !== 2'd0) begin
                errors++;
                $display("[TB] FAIL idle[%0d] got grant=%b gvalid=%b gid=%0d exp 0000/0/0",
                         i, grant4, gvalid4, gid4);
            end
            checks++;
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g [5];
        logic [1:0] exp_id [5];
        if (HOLD) begin
            exp_g  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
            exp_id = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        end else begin
            exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        end
        req4 = 4'b1111;
        #1;
        if (grant4 !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL rot_no_comb got %b exp 0000", grant4);
        end
        checks++;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (grant4 !== exp_g[i] || gid4 !== exp_id[i] || gvalid4 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rot[%0d] got grant=%b gid=%0d gvalid=%b exp %b/%0d/1",
                         i, grant4, gid4, gvalid4, exp_g[i], exp_id[i]);
            end
            checks++;
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_last;
        exp_last = HOLD ? 4'b0001 : 4'b0010;
        req4 = 4'b0100;
        tick();
        if (grant4 !== 4'b0100 || gid4 !== 2'd2) begin
            errors++;
            $display("[TB] FAIL wrap_setup got grant=%b gid=%0d exp 0100/2", grant4, gid4);
        end
        checks++;
        req4 = 4'b0011;
        tick();
        if (grant4 !== 4'b0001 || gid4 !== 2'd0) begin
            errors++;
            $display("[TB] FAIL wrap_first got grant=%b gid=%0d exp 0001/0", grant4, gid4);
        end
        checks++;
        tick();
        if (grant4 !== exp_last) begin
            errors++;
            $display("[TB] FAIL wrap_second got %b exp %b", grant4, exp_last);
        end
        checks++;
    endtask

    task automatic test_hold();
        logic [3:0] exp_g [5];
        if (HOLD) begin
            exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
        end else begin
            exp_g = '{4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0010};
        end
        req4    = 4'b0110;
        nreset4 = 1'b0;
        #1 nreset4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (grant4 !== exp_g[i]) begin
                errors++;
                $display("[TB] FAIL hold[%0d] got %b exp %b", i, grant4, exp_g[i]);
            end
            checks++;
        end
        req4 = 4'b0100;
        tick();
        if (grant4 !== 4'b0100 || gid4 !== 2'd2) begin
            errors++;
            $display("[TB] FAIL hold_release got grant=%b gid=%0d exp 0100/2", grant4, gid4);
        end
        checks++;
    endtask

    task automatic test_enable_reset();
        logic [3:0] exp_after;
        exp_after = HOLD ? 4'b0001 : 4'b1000;
        en4 = 1'b0;
        tick();
        if (grant4 !== 4'b0000 || gvalid4 !== 1'b0 || gid4 !== 2'd0) begin
            errors++;
            $display("[TB] FAIL en_drop got grant=%b gvalid=%b gid=%0d exp 0000/0/0",
                     grant4, gvalid4, gid4);
        end
        checks++;
        en4 = 1'b1;
        tick();
        if (grant4 !== 4'b0100 || gvalid4 !== 1'b1 || gid4 !== 2'd2) begin
            errors++;
            $display("[TB] FAIL en_resume got grant=%b gvalid=%b gid=%0d exp 0100/1/2",
                     grant4, gvalid4, gid4);
        end
        checks++;
        #2 nreset4 = 1'b0;
        #1;
        if (grant4 !== 4'b0000 || gvalid4 !== 1'b0 || gid4 !== 2'd0) begin
            errors++;
            $display("[TB] FAIL async_reset got grant=%b gvalid=%b gid=%0d exp 0000/0/0",
                     grant4, gvalid4, gid4);
        end
        checks++;
        req4 = 4'b1001;
        #1 nreset4 = 1'b1;
        tick();
        if (grant4 !== 4'b0001 || gid4 !== 2'd0 || gvalid4 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset got grant=%b gid=%0d gvalid=%b exp 0001/0/1",
                     grant4, gid4, gvalid4);
        end
        checks++;
        tick();
        if (grant4 !== exp_after) begin
            errors++;
            $display("[TB] FAIL post_reset_next got %b exp %b", grant4, exp_after);
        end
        checks++;
    endtask

    task automatic test_invariant();
        int         wait_cnt [5];
        logic [4:0] prev_grant;
        logic [4:0] r;
        logic       e;
        logic       grant_event;
        for (int i = 0; i < 5; i++) wait_cnt[i] = 0;
        prev_grant = '0;
        en5     = 1'b0;
        req5    = '0;
        #2 nreset5 = 1'b1;
        for (int c = 0; c < 400; c++) begin
            r = 5'($urandom_range(0, 31)) | 5'($urandom_range(0, 31));
            e = ($urandom_range(0, 7) != 0);
            req5 = r;
            en5  = e;
            tick();
            if (!$onehot0(grant5) || gvalid5 !== (|grant5) || gid5 > 3'd4) begin
                errors++;
                $display("[TB] FAIL inv_shape[%0d] got grant=%b gvalid=%b gid=%0d exp onehot0, valid=|grant, gid<5",
                         c, grant5, gvalid5, gid5);
            end
            checks++;
            if (gvalid5 ? (grant5[gid5] !== 1'b1) : (gid5 !== 3'd0)) begin
                errors++;
                $display("[TB] FAIL inv_gid[%0d] got grant=%b gid=%0d gvalid=%b exp grant[gid]==gvalid",
                         c, grant5, gid5, gvalid5);
            end
            checks++;
            if (!e && gvalid5 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL inv_en[%0d] got gvalid=%b exp 0", c, gvalid5);
            end
            checks++;
            grant_event = gvalid5 && (!HOLD || grant5 != prev_grant);
            for (int i = 0; i < 5; i++) begin
                if (!r[i] || grant5[i]) begin
                    wait_cnt[i] = 0;
                end else if (grant_event) begin
                    wait_cnt[i]++;
                end
                if (wait_cnt[i] >= 5) begin
                    errors++;
                    $display("[TB] FAIL fairness[%0d] req %0d waited %0d grants exp < 5",
                             c, i, wait_cnt[i]);
                end
                checks++;
            end
            prev_grant = grant5;
        end
    endtask

    initial begin
        nreset4 = 1'b0;
        en4     = 1'b0;
        req4    = '0;
        nreset5 = 1'b0;
        en5     = 1'b0;
        req5    = '0;
        test_reset();
        test_rotation();
        test_wrap();
        test_hold();
        test_enable_reset();
        test_invariant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
